// File: rtl/disp_pkg.sv
// Shared constants and the 7-segment glyph table for the display controller.
// Segment order is {g,f,e,d,c,b,a}, active-low (common-anode).
package disp_pkg;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;
  localparam logic [1:0] MODE_RESULT = 2'd3;

  localparam logic [1:0] OP_SETSOL = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_e;

  // C/D/E render as a dash, F renders as a blank digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC, 4'hD, 4'hE: glyph = 7'b0111111;
      default: glyph = 7'b1111111;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-scan timebase: prescaler, active digit index (3 = leftmost first),
// frame-end pulse and dead-time flag. Dead time is enabled by DISP_DEADTIME_EN.
module seg_scan_timer
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] digit,
  output logic       frame_end,
  output logic       dead
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYC);
`ifdef DISP_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [PW-1:0] presc_reg;
  logic [1:0]    digit_reg;
  logic          wrap;

  assign wrap = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_reg <= '0;
      digit_reg <= 2'd3;
    end else if (wrap) begin
      presc_reg <= '0;
      digit_reg <= digit_reg - 2'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign digit     = digit_reg;
  // A frame closes when the rightmost digit's slot expires (0 -> 3).
  assign frame_end = wrap && (digit_reg == 2'd0);
  assign dead      = DEAD_EN && (presc_reg < DEAD_LIM);

endmodule

// File: rtl/seg_display_ctrl.sv
// 4-digit multiplexed 7-segment controller with blink, scroll and dp effects.
// Optional anti-ghosting dead time per digit slot via DISP_DEADTIME_EN.
module seg_display_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 25,
  parameter int DEAD_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [1:0]  op,
  input  logic [1:0]  mode,
  input  logic        set,
  input  logic        start,
  input  logic        off,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [1:0] digit;
  logic       frame_end;
  logic       dead;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .digit     (digit),
    .frame_end (frame_end),
    .dead      (dead)
  );

  logic [15:0]  value_reg, value_next;
  logic [1:0]   op_reg, op_next;
  logic [1:0]   mode_reg, mode_next;
  blink_phase_e phase_reg, phase_next;
  logic [1:0]   offset_reg, offset_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic [7:0]   seg_reg, seg_next;
  logic [3:0]   an_reg, an_next;

  logic         load;
  logic [1:0]   sel;
  logic [3:0]   nib;
  logic         blank;
  logic [3:0]   nibbles [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nibbles[gi] = value_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_reg  <= 16'hFFFF;
      op_reg     <= 2'd0;
      mode_reg   <= MODE_STATIC;
      phase_reg  <= PHASE_VISIBLE;
      offset_reg <= 2'd0;
      frame_reg  <= '0;
      seg_reg    <= SEG_BLANK;
      an_reg     <= 4'hF;
    end else begin
      value_reg  <= value_next;
      op_reg     <= op_next;
      mode_reg   <= mode_next;
      phase_reg  <= phase_next;
      offset_reg <= offset_next;
      frame_reg  <= frame_next;
      seg_reg    <= seg_next;
      an_reg     <= an_next;
    end
  end

  always_comb begin
    load        = set && !off;
    value_next  = value_reg;
    op_next     = op_reg;
    mode_next   = mode_reg;
    phase_next  = phase_reg;
    offset_next = offset_reg;
    frame_next  = frame_reg;

    if (load) begin
      value_next = value_in;
      op_next    = op;
      mode_next  = mode;
    end

    // A mode switch restarts the effect cleanly, overriding any frame wrap.
    if (load && (mode != mode_reg)) begin
      phase_next  = PHASE_VISIBLE;
      offset_next = 2'd0;
      frame_next  = '0;
    end else if (!start) begin
      phase_next  = PHASE_VISIBLE;
      offset_next = 2'd0;
    end else if (frame_end) begin
      if (frame_reg == FRAME_LAST) begin
        frame_next = '0;
        if (mode_reg == MODE_BLINK)
          phase_next = (phase_reg == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
        if (mode_reg == MODE_SCROLL)
          offset_next = offset_reg + 2'd1;
      end else begin
        frame_next = frame_reg + 1'b1;
      end
    end
  end

  always_comb begin
    // Scrolling left: the digit at position p shows the character p+offset
    // places from the left, i.e. nibble index (digit - offset) mod 4.
    sel   = (mode_reg == MODE_SCROLL) ? (digit - offset_reg) : digit;
    nib   = nibbles[sel];
    blank = off || ((mode_reg == MODE_BLINK) && (phase_reg == PHASE_HIDDEN)) || dead;
    if (blank) begin
      seg_next = SEG_BLANK;
      an_next  = 4'hF;
    end else begin
      seg_next = {~(op_reg == OP_SETSOL), seg_decode(nib)};
      an_next  = ~(4'b0001 << digit);
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed scenarios followed by
// randomized stimulus, compared every cycle against a timeline-based model.
module tb_seg_display_ctrl;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int DC = 1;
`ifdef DISP_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [1:0]  op;
  logic [1:0]  mode;
  logic        set;
  logic        start;
  logic        off;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_ctrl #(
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF),
    .DEAD_CYC     (DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .op       (op),
    .mode     (mode),
    .set      (set),
    .start    (start),
    .off      (off),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  // Reference state: time since reset plus the user-visible effect state.
  int          t;
  logic [15:0] m_val;
  logic [1:0]  m_op;
  logic [1:0]  m_mode;
  int          m_frames;
  bit          m_hidden;
  int          m_ofs;
  logic [6:0]  glyph_tab [16];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_val    = 16'hFFFF;
    m_op     = 2'd0;
    m_mode   = 2'd0;
    m_frames = 0;
    m_hidden = 1'b0;
    m_ofs    = 0;
  endtask

  task automatic tick();
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic [3:0] nib;
    int presc, digit, pos, chr, zeros;
    bit blank, frame_done, load, mchg;
    @(posedge clk);
    if (!rst) begin
      e_seg = 8'hFF;
      e_an  = 4'hF;
      model_reset();
    end else begin
      presc = t % SD;
      digit = 3 - ((t / SD) % 4);
      pos   = 3 - digit;
      blank = off || (m_mode == 2'd1 && m_hidden) || (DEAD_EN && presc < DC);
      chr   = (m_mode == 2'd2) ? (pos + m_ofs) % 4 : pos;
      nib   = 4'((m_val >> (12 - 4 * chr)) & 16'hF);
      if (blank) begin
        e_seg = 8'hFF;
        e_an  = 4'hF;
      end else begin
        e_seg = {(m_op != 2'd2), glyph_tab[nib]};
        e_an  = 4'hF ^ (4'b0001 << digit);
      end
      frame_done = (presc == SD - 1) && (digit == 0);
      load = set && !off;
      mchg = load && (mode != m_mode);
      if (mchg) begin
        m_frames = 0;
        m_hidden = 1'b0;
        m_ofs    = 0;
      end else if (!start) begin
        m_hidden = 1'b0;
        m_ofs    = 0;
      end else if (frame_done) begin
        m_frames++;
        if (m_frames == BF) begin
          m_frames = 0;
          if (m_mode == 2'd1) m_hidden = !m_hidden;
          if (m_mode == 2'd2) m_ofs = (m_ofs + 1) % 4;
        end
      end
      if (load) begin
        m_val  = value_in;
        m_op   = op;
        m_mode = mode;
      end
      t++;
    end
    #1;
    check("seg", {8'h00, seg}, {8'h00, e_seg});
    check("an", {12'h000, an}, {12'h000, e_an});
    zeros = 0;
    for (int i = 0; i < 4; i++) if (an[i] === 1'b0) zeros++;
    check("an_onehot", 16'(zeros <= 1), 16'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [1:0] o, input logic [1:0] m);
    value_in = v;
    op       = o;
    mode     = m;
    set      = 1'b1;
    tick();
    set = 1'b0;
  endtask

  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b0111111; glyph_tab[13] = 7'b0111111;
    glyph_tab[14] = 7'b0111111; glyph_tab[15] = 7'b1111111;
    model_reset();

    rst = 1'b0; value_in = 16'h0; op = 2'd0; mode = 2'd0;
    set = 1'b0; start = 1'b0; off = 1'b0;
    run(2);
    rst = 1'b1;
    $display("phase reset done");

    load_once(16'h1234, 2'd0, 2'd0); run(20);
    $display("phase static 1234 done");
    load_once(16'h3A1B, 2'd0, 2'd3); run(20);
    load_once(16'hFFFF, 2'd0, 2'd3); run(20);
    $display("phase glyphs done");
    load_once(16'h5678, 2'd2, 2'd0); run(20);
    load_once(16'h5678, 2'd0, 2'd0); run(20);
    $display("phase dp done");

    start = 1'b1;
    load_once(16'h1234, 2'd0, 2'd1); run(140);
    start = 1'b0; run(10);
    $display("phase blink done");

    start = 1'b1;
    load_once(16'h1234, 2'd0, 2'd2); run(150);
    load_once(16'h1234, 2'd0, 2'd0); run(6);
    $display("phase scroll done");

    off = 1'b1; run(6);
    off = 1'b0; run(4);
    load_once(16'h1234, 2'd0, 2'd2); run(75);
    rst = 1'b0; tick();
    rst = 1'b1; run(20);
    $display("phase off/reset done");

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 799) != 0);
      set = ($urandom_range(0, 39) == 0);
      if (set) begin
        value_in = 16'($urandom);
        op       = 2'($urandom_range(0, 3));
        mode     = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 63) == 0) start = !start;
      if ($urandom_range(0, 49) == 0) off = !off;
      tick();
    end
    $display("phase random done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Receiving end of the game core's display interface: consumes core_value_out, core_op, core_mode, set, start and off.
- Drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Adds blink (congrat), scroll and decimal-point (solution-entry) effects.
- Sits between the game core FSM and board pins; owns all display timing.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays selected; must be >= 2.
- BLINK_FRAMES, 25: full 4-digit frames per blink or scroll step; must be >= 1.
- DEAD_CYC, 4: blanking cycles at each digit switch (used only with DISP_DEADTIME_EN); must be < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- value_in  in  16  four BCD-ish nibbles, [15:12] = leftmost digit
- op  in  2  2 = solution-entry (all dp on); 0, 1, 3 = dp off
- mode  in  2  0 = static, 1 = blink all, 2 = scroll left, 3 = static
- set  in  1  load enable for value/op/mode shadow registers
- start  in  1  run enable for blink/scroll timers
- off  in  1  blank all digits
- seg  out  8  active-low; [7] = dp, [6:0] = g..a
- an  out  4  active-low digit enables; an[3] = leftmost

Behaviour:
- Reset (rst==0 at clk edge), next-cycle values:
  - seg = 8'hFF, an = 4'hF.
  - Shadow value = 16'hFFFF, shadow op = 0, shadow mode = 0.
  - Prescaler = 0, digit index = 3, frame count = 0, blink phase = visible, scroll offset = 0.
- Shadow load: when set==1 and off==0 on an edge, value_in/op/mode are registered that edge. set is level-sensitive and reloads every cycle while high; when set==0 the shadow holds.
- Mode change: if the loaded mode differs from the shadow mode, also clear blink phase to visible, scroll offset to 0, and frame count to 0, in the same edge.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index decrements 3->2->1->0->3.
  - On the 0->3 transition a frame ends and frame count increments.
- Frame count wraps at BLINK_FRAMES-1:
  - if start==1 and mode==1, blink phase toggles;
  - if start==1 and mode==2, scroll offset increments mod 4.
- start==0: frame count holds, blink phase forced visible, scroll offset forced 0. Scanning continues regardless of start.
- Displayed nibble for physical digit i = shadow nibble at ((i + scroll offset) mod 4); offset is 0 in modes other than 2.
- Decode: 0-9 digit glyphs, A = 'A' (7'b0001000), B = 'b' (7'b0000011), C/D/E = '-' (7'b0111111), F = blank (7'b1111111).
- dp: seg[7] = 0 iff shadow op == 2 and the digit is not blanked.
- Blanking: an = 4'hF and seg = 8'hFF whenever any of:
  - off == 1;
  - mode == 1 and blink phase is hidden;
  - inside a dead-time window.
- Latency:
  - seg/an are registered; a new value reaches the pins 2 cycles after set goes high (shadow, then output), visible when its digit is scanned.
  - off asserts/deasserts with 1-cycle latency, independent of set.
- Simultaneous set and frame wrap: the load wins for value; the phase/offset update still applies unless the mode changed.
- Reset mid-frame: everything returns to reset values next edge; no partial digit is driven.
- Exactly one an bit is low at any time, or none.

Optional Feature:
- Macro DISP_DEADTIME_EN.
- Defined: the first DEAD_CYC cycles after each digit switch (prescaler < DEAD_CYC) force an = 4'hF and seg = 8'hFF, to suppress ghosting.
- Undefined: no dead time; the new digit drives immediately on switch; DEAD_CYC is ignored.

Decomposition:
- Package disp_pkg:
  - mode constants MODE_STATIC = 0, MODE_BLINK = 1, MODE_SCROLL = 2, MODE_RESULT = 3;
  - OP_SETSOL = 2;
  - 16-entry glyph table/function seg_decode(nibble) -> 7 bits;
  - SEG_BLANK = 8'hFF.
- Sub-module seg_scan_timer: prescaler, digit index, frame-end pulse and dead-time flag.
- The top level holds shadow registers, blink/scroll state and output registers.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, DEAD_CYC=1):
- Reset, then set=1 with value_in=16'h1234, mode=0, op=0, off=0, for 1 cycle -> over 16 cycles an cycles 0111/1011/1101/1110 with seg[6:0] = 1111001 / 0100100 / 0110000 / 0011001, dp=1.
- value_in=16'h3A1B, mode=3 -> digits show '3', 'A', '1', 'b'; value 16'hFFFF -> an active but seg=8'hFF.
- op=2, value 16'h5678 -> seg[7]=0 on every scanned digit; op=0 -> seg[7]=1.
- mode=1, start=1 -> display visible 2 frames (32 cycles) then fully blank 32 cycles, repeating; start=0 -> visible within 1 cycle.
- mode=2, start=1, value 16'h1234 -> shows 1234, 2341, 3412, 4123, then 1234 again, each step 32 cycles; switching to mode=0 -> 1234 immediately.
- off=1 mid-frame -> an=4'hF next cycle; rst=0 mid-scroll -> seg=8'hFF, an=4'hF, offset 0. With DISP_DEADTIME_EN, the first cycle of each digit slot has an=4'hF.
